hd44780_bus_sender: RTL and testbench

Parametrised successor to the nybble sender. It accepts one command or data byte and drives a complete HD44780 write cycle on either a 4-bit or 8-bit LCD bus. The write cycle covers RS/data setup, the E pulse, hold and a caller-specified post-write settle delay. It sits between the controller state machine and the LCD pins, and replaces the separate nybble-sender-plus-state-timer pairing for each write.

---
 rtl/hd44780_bus_sender.sv | 195 +++++++++++++++++++
 tb/tb_hd44780_bus_sender.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_bus_sender.sv
// -----------------------------------------------------------------------------
// hd44780_bus_sender
//
// Drives one complete HD44780 write cycle for a command or data byte on a
// 4-bit or 8-bit LCD bus. This covers RS/data setup, the E pulse, the hold
// time and an optional settle delay requested by the caller. A 4-bit full
// byte is sent as two nybbles, upper nybble first. With i_half=1 only the
// upper nybble is sent, which the LCD init sequence needs.
//
// Handshake: a request is taken on any rising edge where the FSM is IDLE
// and STB_I=1. o_busy is then high from the following cycle until the
// transfer is done. STB_I is ignored while o_busy=1, and requests are not
// queued. The cycle after the last busy cycle has o_busy=0 and o_ack=1 for
// exactly one cycle. That ack cycle is IDLE, so STB_I=1 there starts the
// next transfer on the same edge.
//
// Parameters
//   BUS_WIDTH   4 or 8, LCD data bus width
//   TIMER_BITS  width of i_wait and of the settle count
//   SETUP_CYC   cycles RS/data are stable before E rises (0 acts as 1)
//   E_HIGH_CYC  cycles E is high (0 acts as 1)
//   HOLD_CYC    cycles RS/data are held after E falls (0 acts as 1)
//
// Ports
//   CLK_I       system clock, rising edge
//   RST_I       asynchronous active-low reset
//   STB_I       transfer request, sampled only while idle
//   i_rs        register select for this transfer
//   i_data      byte to send
//   i_half      4-bit mode only: send the upper nybble alone
//   i_wait      settle cycles after the final hold (0 = no settle phase)
//   o_busy      transfer in progress
//   o_ack       one-cycle completion strobe
//   o_rs        LCD RS pin
//   o_e         LCD E pin (registered, glitch-free)
//   o_lcd_data  LCD data pins
//   o_state     current FSM state, for debug (IDLE encodes as 0)
// -----------------------------------------------------------------------------
module hd44780_bus_sender #(
    parameter int BUS_WIDTH  = 4,
    parameter int TIMER_BITS = 16,
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int HOLD_CYC   = 2
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  STB_I,
    input  logic                  i_rs,
    input  logic [7:0]            i_data,
    input  logic                  i_half,
    input  logic [TIMER_BITS-1:0] i_wait,
    output logic                  o_busy,
    output logic                  o_ack,
    output logic                  o_rs,
    output logic                  o_e,
    output logic [BUS_WIDTH-1:0]  o_lcd_data,
    output logic [2:0]            o_state
);

    // A cycle count of zero is treated as one.
    localparam int S_EFF = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int E_EFF = (E_HIGH_CYC < 1) ? 1 : E_HIGH_CYC;
    localparam int H_EFF = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;

    localparam int MAX_SE = (S_EFF > E_EFF) ? S_EFF : E_EFF;
    localparam int MAX_PH = (MAX_SE > H_EFF) ? MAX_SE : H_EFF;
    localparam int PH_W   = $clog2(MAX_PH + 1);

    // The counter must be wide enough for every phase length. That
    // includes the largest i_wait, which is loaded as i_wait-1, so it
    // never wraps.
    localparam int CNT_W = (TIMER_BITS > PH_W) ? TIMER_BITS : PH_W;

    localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(S_EFF - 1);
    localparam logic [CNT_W-1:0] E_LOAD = CNT_W'(E_EFF - 1);
    localparam logic [CNT_W-1:0] H_LOAD = CNT_W'(H_EFF - 1);

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
        $error("hd44780_bus_sender: BUS_WIDTH must be 4 or 8");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        EHIGH  = 3'd2,
        HOLD   = 3'd3,
        SETTLE = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [BUS_WIDTH-1:0]   data_q;     // low BUS_WIDTH bits of the byte
    logic                   half_q;
    logic [TIMER_BITS-1:0]  wait_q;
    logic                   second;     // second nybble is on the bus
    logic [BUS_WIDTH-1:0]   first_word;
    logic                   two_phase;

    // First word on the bus: the upper nybble in 4-bit mode, the whole
    // byte in 8-bit mode. data_q holds the second word in 4-bit mode.
    if (BUS_WIDTH == 8) begin : g_w8
        assign first_word = i_data;
    end else begin : g_w4
        assign first_word = i_data[7:4];
    end

    assign two_phase = (BUS_WIDTH == 4) && !half_q;
    assign o_state   = state;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state      <= IDLE;
            cnt        <= '0;
            data_q     <= '0;
            half_q     <= 1'b0;
            wait_q     <= '0;
            second     <= 1'b0;
            o_busy     <= 1'b0;
            o_ack      <= 1'b0;
            o_rs       <= 1'b0;
            o_e        <= 1'b0;
            o_lcd_data <= '0;
        end else begin
            o_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (STB_I) begin
                        data_q     <= i_data[BUS_WIDTH-1:0];
                        half_q     <= i_half;
                        wait_q     <= i_wait;
                        second     <= 1'b0;
                        o_busy     <= 1'b1;
                        o_rs       <= i_rs;
                        o_lcd_data <= first_word;
                        cnt        <= S_LOAD;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        o_e   <= 1'b1;
                        cnt   <= E_LOAD;
                        state <= EHIGH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                EHIGH: begin
                    if (cnt == '0) begin
                        o_e   <= 1'b0;
                        cnt   <= H_LOAD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        if (two_phase && !second) begin
                            second     <= 1'b1;
                            o_lcd_data <= data_q;
                            cnt        <= S_LOAD;
                            state      <= SETUP;
                        end else if (wait_q != '0) begin
                            cnt   <= CNT_W'(wait_q) - CNT_W'(1);
                            state <= SETTLE;
                        end else begin
                            o_busy <= 1'b0;
                            o_ack  <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        o_busy <= 1'b0;
                        o_ack  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    o_e    <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_bus_sender.sv
// -----------------------------------------------------------------------------
// tb_hd44780_bus_sender
//
// Three instances are tested side by side:
//   0: BUS_WIDTH=4, S=2, E=3, H=2
//   1: BUS_WIDTH=8, default timing (S=2, E=12, H=2)
//   2: BUS_WIDTH=8, TIMER_BITS=4, S=E=H=0 (each clamps to 1)
// The reference model expands each transfer into a cycle-by-cycle list of
// the expected {busy, ack, e, rs, data} values. It builds that list from
// the phase rules: each nybble or byte gives S setup cycles, E high cycles
// and H hold cycles, then W settle cycles follow, then one ack cycle.
// -----------------------------------------------------------------------------
module tb_hd44780_bus_sender;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stb    [N];
    logic        rs_i   [N];
    logic        half_i [N];
    logic [7:0]  data_i [N];
    logic [15:0] wt_i   [N];

    logic        busy_o [N];
    logic        ack_o  [N];
    logic        rs_o   [N];
    logic        e_o    [N];
    logic [7:0]  dat_o  [N];
    logic [2:0]  st_o   [N];

    logic [3:0]  a_lcd;
    logic [7:0]  b_lcd;
    logic [7:0]  c_lcd;

    assign dat_o[0] = {4'h0, a_lcd};
    assign dat_o[1] = b_lcd;
    assign dat_o[2] = c_lcd;

    hd44780_bus_sender #(
        .BUS_WIDTH(4), .TIMER_BITS(16), .SETUP_CYC(2), .E_HIGH_CYC(3), .HOLD_CYC(2)
    ) u_a (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb[0]), .i_rs(rs_i[0]),
        .i_data(data_i[0]), .i_half(half_i[0]), .i_wait(wt_i[0]),
        .o_busy(busy_o[0]), .o_ack(ack_o[0]), .o_rs(rs_o[0]), .o_e(e_o[0]),
        .o_lcd_data(a_lcd), .o_state(st_o[0])
    );

    hd44780_bus_sender #(
        .BUS_WIDTH(8)
    ) u_b (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb[1]), .i_rs(rs_i[1]),
        .i_data(data_i[1]), .i_half(half_i[1]), .i_wait(wt_i[1]),
        .o_busy(busy_o[1]), .o_ack(ack_o[1]), .o_rs(rs_o[1]), .o_e(e_o[1]),
        .o_lcd_data(b_lcd), .o_state(st_o[1])
    );

    hd44780_bus_sender #(
        .BUS_WIDTH(8), .TIMER_BITS(4), .SETUP_CYC(0), .E_HIGH_CYC(0), .HOLD_CYC(0)
    ) u_c (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb[2]), .i_rs(rs_i[2]),
        .i_data(data_i[2]), .i_half(half_i[2]), .i_wait(wt_i[2][3:0]),
        .o_busy(busy_o[2]), .o_ack(ack_o[2]), .o_rs(rs_o[2]), .o_e(e_o[2]),
        .o_lcd_data(c_lcd), .o_state(st_o[2])
    );

    // Model timing per instance (effective, already clamped).
    int bw [N] = '{4, 8, 8};
    int sc [N] = '{2, 2, 1};
    int ec [N] = '{3, 12, 1};
    int hc [N] = '{2, 2, 1};

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  last_word;

    task automatic check(input string name, input int k, input int cyc,
                         input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got {busy,ack,e,rs,data}=%h expected %h",
                     name, k, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] pack(input logic b, input logic a, input logic e,
                                         input logic r, input logic [7:0] d);
        return {b, a, e, r, d};
    endfunction

    function automatic logic [11:0] obs(input int k);
        return {busy_o[k], ack_o[k], e_o[k], rs_o[k], dat_o[k]};
    endfunction

    // Build the expected cycle list for one transfer on instance k.
    task automatic build(input int k, input logic rs, input logic [7:0] data,
                         input logic half, input int wt);
        int phases;
        logic [7:0] word;
        exp_q.delete();
        phases = (bw[k] == 4 && !half) ? 2 : 1;
        word = 8'h00;
        for (int p = 0; p < phases; p++) begin
            if (bw[k] == 8)  word = data;
            else if (p == 0) word = {4'h0, data[7:4]};
            else             word = {4'h0, data[3:0]};
            for (int i = 0; i < sc[k]; i++) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, rs, word));
            for (int i = 0; i < ec[k]; i++) exp_q.push_back(pack(1'b1, 1'b0, 1'b1, rs, word));
            for (int i = 0; i < hc[k]; i++) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, rs, word));
        end
        for (int i = 0; i < wt; i++) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, rs, word));
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, rs, word));
        last_word = word;
    endtask

    // Run one transfer starting at a negedge. ign: busy cycle at which a
    // stray STB_I with data 0xFF is pulsed (0 = none). keep: raise STB_I in
    // the last busy cycle and return at the ack-cycle negedge with it still
    // high, so the next call's request is taken at the ack edge.
    task automatic xfer(input int k, input logic rs, input logic [7:0] data,
                        input logic half, input int wt, input int ign, input logic keep);
        int n;
        logic [11:0] e;
        build(k, rs, data, half, wt);
        rs_i[k]   = rs;
        data_i[k] = data;
        half_i[k] = half;
        wt_i[k]   = 16'(wt);
        stb[k]    = 1'b1;
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            n++;
            if (n == 1) stb[k] = 1'b0;
            e = exp_q.pop_front();
            check(exp_q.size() == 0 ? "ack" : "busy", k, n, obs(k), e);
            if (ign != 0 && n == ign) begin
                stb[k]    = 1'b1;
                data_i[k] = 8'hFF;
            end
            if (ign != 0 && n == ign + 1) stb[k] = 1'b0;
            if (keep && exp_q.size() == 1) stb[k] = 1'b1;
        end
        if (!keep) begin
            @(negedge clk);
            check("idle", k, n + 1, obs(k), pack(1'b0, 1'b0, 1'b0, rs, last_word));
            check("idle_state", k, n + 1, {9'h0, st_o[k]}, 12'h0);
        end
    endtask

    typedef struct {
        int         k;
        logic       rs;
        logic [7:0] data;
        logic       half;
        int         wt;
        int         ign;
        logic       keep;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 1'b0, 8'h28, 1'b0, 5,  0, 1'b0};
        vecs[1] = '{0, 1'b0, 8'h30, 1'b1, 0,  0, 1'b0};
        vecs[2] = '{1, 1'b1, 8'hA5, 1'b0, 0,  0, 1'b0};
        vecs[3] = '{0, 1'b0, 8'h28, 1'b0, 5,  4, 1'b1};
        vecs[4] = '{0, 1'b1, 8'h4F, 1'b0, 2,  0, 1'b0};
        vecs[5] = '{2, 1'b0, 8'h3C, 1'b0, 15, 0, 1'b0};
        vecs[6] = '{1, 1'b1, 8'h81, 1'b1, 3,  0, 1'b0};
        vecs[7] = '{0, 1'b1, 8'hC3, 1'b1, 4,  0, 1'b0};

        // Clock/reset
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            stb[k] = 1'b0; rs_i[k] = 1'b0; half_i[k] = 1'b0;
            data_i[k] = 8'h00; wt_i[k] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("reset_out", k, 0, obs(k), 12'h000);
            check("reset_state", k, 0, {9'h0, st_o[k]}, 12'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) check("post_reset", k, 0, obs(k), 12'h000);

        // Directed vectors
        for (int v = 0; v < 8; v++)
            xfer(vecs[v].k, vecs[v].rs, vecs[v].data, vecs[v].half,
                 vecs[v].wt, vecs[v].ign, vecs[v].keep);

        // Reset during E high of the second nybble on instance 0.
        rs_i[0] = 1'b1; data_i[0] = 8'h7C; half_i[0] = 1'b0; wt_i[0] = 16'd5;
        stb[0] = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n == 1) stb[0] = 1'b0;
        end
        check("pre_abort", 0, 11, obs(0), pack(1'b1, 1'b0, 1'b1, 1'b1, 8'h0C));
        rst_n = 1'b0;
        #1;
        check("abort_out", 0, 11, obs(0), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (ack_o[0] !== 1'b0 || busy_o[0] !== 1'b0) bad++;
            end
            check("no_ack_after_abort", 0, 0, 12'(bad), 12'h0);
        end
        xfer(0, 1'b0, 8'h06, 1'b0, 1, 0, 1'b0);

        // Randomized transfers against the model
        begin
            int k;
            int wt;
            int ign;
            logic keep;
            logic forced;
            forced = 1'b0;
            k = 0;
            for (int it = 0; it < 40; it++) begin
                if (!forced) k = $urandom_range(0, N - 1);
                case (k)
                    0:       wt = $urandom_range(0, 6);
                    1:       wt = $urandom_range(0, 4);
                    default: wt = $urandom_range(0, 15);
                endcase
                ign  = ($urandom_range(0, 1) == 1) ? 2 : 0;
                keep = (it != 39) && ($urandom_range(0, 3) == 0);
                xfer(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), wt, ign, keep);
                forced = keep;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
